// File: rtl/data_memory_ctrl.sv
// Byte/halfword/word data memory with RV32I load/store semantics behind a
// valid/ready request/response handshake and a configurable access latency.
module data_memory_ctrl #(
    parameter int unsigned DEPTH_WORDS = 32,
    parameter int unsigned LATENCY     = 1,
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [31:0]                  req_addr,
    input  logic [2:0]                   req_funct3,
    input  logic [31:0]                  req_wdata,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [31:0]                  resp_rdata,
    output logic                         resp_error,
    input  logic [DEPTH_WORDS-1:0][31:0] initial_values,
    output logic [DEPTH_WORDS-1:0][31:0] memory_check
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                        state_q;
    logic [2:0]                    cnt_q;
    logic                          write_q;
    logic [31:0]                   addr_q;
    logic [2:0]                    funct3_q;
    logic [31:0]                   wdata_q;
    logic [DEPTH_WORDS-1:0][31:0]  mem_q;

    logic                          acc_write;
    logic [31:0]                   acc_addr;
    logic [2:0]                    acc_funct3;
    logic [31:0]                   acc_wdata;
    logic [IDX_W-1:0]              idx;
    logic [1:0]                    lane;
    logic [31:0]                   word;
    logic [7:0]                    byte_sel;
    logic [15:0]                   half_sel;
    logic                          out_of_range;
    logic                          illegal;
    logic                          misaligned;
    logic                          acc_error;
    logic [31:0]                   load_data;
    logic [31:0]                   store_word;
    logic                          enter_resp;

    // With zero latency the access happens on the accept edge, before the
    // request fields are latched, so decode straight from the request inputs.
    assign acc_write  = (state_q == StIdle) ? req_write  : write_q;
    assign acc_addr   = (state_q == StIdle) ? req_addr   : addr_q;
    assign acc_funct3 = (state_q == StIdle) ? req_funct3 : funct3_q;
    assign acc_wdata  = (state_q == StIdle) ? req_wdata  : wdata_q;

    assign enter_resp = (state_q == StIdle && req_valid && req_ready && LATENCY == 0) ||
                        (state_q == StWait && cnt_q == 3'd0);

    assign memory_check = mem_q;

    always_comb begin
        idx          = acc_addr[IDX_W+1:2];
        lane         = acc_addr[1:0];
        word         = mem_q[idx];
        byte_sel     = word[{lane, 3'b000} +: 8];
        half_sel     = lane[1] ? word[31:16] : word[15:0];
        out_of_range = (acc_addr >> (IDX_W + 2)) != 32'd0;
        if (acc_write) begin
            illegal = !(acc_funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            illegal = !(acc_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
        misaligned = (acc_funct3[1:0] == 2'b01 && lane[0]) ||
                     (acc_funct3[1:0] == 2'b10 && lane != 2'b00);
        acc_error  = out_of_range || illegal || misaligned;

        load_data = 32'd0;
        case (acc_funct3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'd0, half_sel};
            3'b010:  load_data = word;
            default: load_data = 32'd0;
        endcase

        store_word = word;
        case (acc_funct3)
            3'b000:  store_word[{lane, 3'b000} +: 8]       = acc_wdata[7:0];
            3'b001:  store_word[{lane[1], 4'b0000} +: 16]  = acc_wdata[15:0];
            3'b010:  store_word                            = acc_wdata;
            default: store_word                            = word;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
            cnt_q      <= 3'd0;
            write_q    <= 1'b0;
            addr_q     <= 32'd0;
            funct3_q   <= 3'd0;
            wdata_q    <= 32'd0;
            mem_q      <= initial_values;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        write_q   <= req_write;
                        addr_q    <= req_addr;
                        funct3_q  <= req_funct3;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            state_q    <= StResp;
                            resp_valid <= 1'b1;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= 3'(LATENCY - 1);
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 3'd0) begin
                        state_q    <= StResp;
                        resp_valid <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                StResp: begin
                    if (resp_valid && resp_ready) begin
                        state_q    <= StIdle;
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'd0;
                        resp_error <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (enter_resp) begin
                if (acc_write && !acc_error) begin
                    mem_q[idx] <= store_word;
                end
                resp_rdata <= (acc_write || acc_error) ? 32'd0 : load_data;
                resp_error <= acc_error;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: three instances at latencies 2, 0 and 3
// share request fields and reset; each has its own handshake.
module tb_data_memory_ctrl;

    localparam int unsigned DEPTH = 32;
    localparam int NDUT = 3;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   req_write = 1'b0;
    logic [31:0]            req_addr = 32'd0;
    logic [2:0]             req_funct3 = 3'd0;
    logic [31:0]            req_wdata = 32'd0;
    logic [DEPTH-1:0][31:0] init_vals;

    logic                   req_valid  [NDUT];
    logic                   resp_ready [NDUT];
    logic                   req_ready  [NDUT];
    logic                   resp_valid [NDUT];
    logic [31:0]            resp_rdata [NDUT];
    logic                   resp_error [NDUT];
    logic [DEPTH-1:0][31:0] mem_chk    [NDUT];

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        data_memory_ctrl #(
            .DEPTH_WORDS (DEPTH),
            .LATENCY     (g == 0 ? 2 : (g == 1 ? 0 : 3))
        ) dut (
            .clk            (clk),
            .reset          (reset),
            .req_valid      (req_valid[g]),
            .req_ready      (req_ready[g]),
            .req_write      (req_write),
            .req_addr       (req_addr),
            .req_funct3     (req_funct3),
            .req_wdata      (req_wdata),
            .resp_valid     (resp_valid[g]),
            .resp_ready     (resp_ready[g]),
            .resp_rdata     (resp_rdata[g]),
            .resp_error     (resp_error[g]),
            .initial_values (init_vals),
            .memory_check   (mem_chk[g])
        );
    end

    function automatic int lat_of(input int s);
        return (s == 0) ? 2 : ((s == 1) ? 0 : 3);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drive one request on instance s, time its response, compare against the
    // scoreboard entry, then complete the handshake.
    task automatic xact(input int s, input logic w, input logic [31:0] a, input logic [2:0] f,
                        input logic [31:0] wd, input logic [31:0] exp_rdata, input logic exp_err,
                        input string tag);
        int   n;
        exp_t e;
        sb.push_back('{rdata: exp_rdata, err: exp_err});
        @(negedge clk);
        check({tag, ".req_ready"}, 32'(req_ready[s]), 32'd1);
        req_write    = w;
        req_addr     = a;
        req_funct3   = f;
        req_wdata    = wd;
        req_valid[s] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[s] = 1'b0;
        n = 1;
        while (!resp_valid[s] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'(1 + lat_of(s)));
        e = sb.pop_front();
        check({tag, ".rdata"}, resp_rdata[s], e.rdata);
        check({tag, ".error"}, 32'(resp_error[s]), 32'(e.err));
        resp_ready[s] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[s] = 1'b0;
        check({tag, ".done"}, {30'd0, req_ready[s], resp_valid[s]}, 32'b10);
    endtask

    initial begin
        exp_t e;
        logic [31:0] held;
        for (int i = 0; i < int'(DEPTH); i++) begin
            init_vals[i] = {8'(i), 8'hC3, 8'(i * 3), 8'h5A};
        end
        init_vals[1] = 32'h8070_F0A5;
        init_vals[2] = 32'h1122_3344;
        for (int s = 0; s < NDUT; s++) begin
            req_valid[s]  = 1'b0;
            resp_ready[s] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < NDUT; s++) begin
            check($sformatf("rst%0d.flags", s),
                  {29'd0, req_ready[s], resp_valid[s], resp_error[s]}, 32'b100);
            check($sformatf("rst%0d.rdata", s), resp_rdata[s], 32'd0);
            check($sformatf("rst%0d.mem1", s), mem_chk[s][1], 32'h8070_F0A5);
        end
        @(negedge clk);
        reset = 1'b0;

        // Latency 2: load extension and alignment.
        xact(0, 1'b0, 32'h4, 3'b000, 32'h0, 32'hFFFF_FFA5, 1'b0, "lb4");
        xact(0, 1'b0, 32'h4, 3'b100, 32'h0, 32'h0000_00A5, 1'b0, "lbu4");
        xact(0, 1'b0, 32'h6, 3'b001, 32'h0, 32'hFFFF_8070, 1'b0, "lh6");
        xact(0, 1'b0, 32'h4, 3'b101, 32'h0, 32'h0000_F0A5, 1'b0, "lhu4");
        xact(0, 1'b0, 32'h5, 3'b001, 32'h0, 32'h0, 1'b1, "lh5_mis");
        xact(0, 1'b0, 32'h7, 3'b100, 32'h0, 32'h0000_0080, 1'b0, "lbu7");
        // Stores preserve untouched lanes.
        xact(0, 1'b1, 32'h9, 3'b000, 32'hFFFF_FFAB, 32'h0, 1'b0, "sb9");
        check("sb9.mem2", mem_chk[0][2], 32'h1122_AB44);
        xact(0, 1'b1, 32'hA, 3'b001, 32'h1234_BEEF, 32'h0, 1'b0, "shA");
        check("shA.mem2", mem_chk[0][2], 32'hBEEF_AB44);
        xact(0, 1'b0, 32'h8, 3'b010, 32'h0, 32'hBEEF_AB44, 1'b0, "lw8");
        // Errors leave the array alone.
        xact(0, 1'b1, 32'h80, 3'b010, 32'hDEAD_BEEF, 32'h0, 1'b1, "sw80_oor");
        check("sw80.mem0", mem_chk[0][0], init_vals[0]);
        check("sw80.mem31", mem_chk[0][31], init_vals[31]);
        xact(0, 1'b1, 32'h2, 3'b010, 32'hDEAD_BEEF, 32'h0, 1'b1, "sw2_mis");
        check("sw2.mem0", mem_chk[0][0], init_vals[0]);
        xact(0, 1'b0, 32'h4, 3'b011, 32'h0, 32'h0, 1'b1, "ld011");
        xact(0, 1'b1, 32'h4, 3'b100, 32'h0, 32'h0, 1'b1, "st100");
        check("st100.mem1", mem_chk[0][1], 32'h8070_F0A5);
        xact(0, 1'b1, 32'h7C, 3'b010, 32'h0BAD_F00D, 32'h0, 1'b0, "sw7c");
        xact(0, 1'b0, 32'h7C, 3'b010, 32'h0, 32'h0BAD_F00D, 1'b0, "lw7c");

        // Latency 0 with a stalled consumer and a request held during RESP.
        xact(1, 1'b0, 32'h4, 3'b010, 32'h0, 32'h8070_F0A5, 1'b0, "l0_lw4");
        sb.push_back('{rdata: 32'h8070_F0A5, err: 1'b0});
        @(negedge clk);
        req_write    = 1'b0;
        req_addr     = 32'h4;
        req_funct3   = 3'b010;
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        check("hold.accept", 32'(resp_valid[1]), 32'd1);
        req_write  = 1'b1;
        req_addr   = 32'h0;
        req_wdata  = 32'hDEAD_BEEF;
        e = sb.pop_front();
        held = e.rdata;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d.flags", i), {30'd0, resp_valid[1], req_ready[1]}, 32'b10);
            check($sformatf("hold%0d.rdata", i), resp_rdata[1], held);
        end
        req_valid[1]  = 1'b0;
        resp_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[1] = 1'b0;
        check("hold.release", {30'd0, req_ready[1], resp_valid[1]}, 32'b10);
        repeat (2) @(posedge clk);
        #1;
        check("hold.nodouble", 32'(resp_valid[1]), 32'd0);
        check("hold.mem0", mem_chk[1][0], init_vals[0]);

        // Latency 3: plain load, then a store aborted by reset.
        xact(2, 1'b0, 32'h8, 3'b010, 32'h0, 32'h1122_3344, 1'b0, "l3_lw8");
        @(negedge clk);
        req_write    = 1'b1;
        req_addr     = 32'h0;
        req_funct3   = 3'b010;
        req_wdata    = 32'hCAFE_F00D;
        req_valid[2] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        check("abort.accepted", 32'(req_ready[2]), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort.idle", {30'd0, req_ready[2], resp_valid[2]}, 32'b10);
        check("abort.mem0", mem_chk[2][0], init_vals[0]);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort%0d.valid", i), 32'(resp_valid[2]), 32'd0);
        end
        check("abort.mem0_after", mem_chk[2][0], init_vals[0]);
        check("abort.ready_after", 32'(req_ready[2]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of run, expected finish");
        $fatal(1);
    end

endmodule
